// File: rtl/axa_operand_loader_pkg.sv
// axa_operand_loader_pkg
// Shared definitions for the 2x2 operand loader: FSM state encoding,
// operand slot indices (A11..B22 = 0..7), the FP32 exponent-all-ones
// pattern used to spot Inf/NaN, and the default RUN timeout.
package axa_operand_loader_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ACK   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int NUM_OPS = 8;
  localparam int WORD_W  = 32;

  localparam logic [2:0] IDX_A11 = 3'd0;
  localparam logic [2:0] IDX_A12 = 3'd1;
  localparam logic [2:0] IDX_A21 = 3'd2;
  localparam logic [2:0] IDX_A22 = 3'd3;
  localparam logic [2:0] IDX_B11 = 3'd4;
  localparam logic [2:0] IDX_B12 = 3'd5;
  localparam logic [2:0] IDX_B21 = 3'd6;
  localparam logic [2:0] IDX_B22 = 3'd7;

  localparam logic [7:0] FP_EXP_ALL_ONES = 8'hFF;

  localparam int DEF_TIMEOUT_CYCLES = 64;

  // Inf and NaN share the all-ones exponent field [30:23]
  function automatic logic is_inf_nan(input logic [WORD_W-1:0] w);
    return (w[30:23] == FP_EXP_ALL_ONES);
  endfunction

endpackage

// File: rtl/axa_timeout_counter.sv
// axa_timeout_counter
// Free-running up counter with synchronous clear and a terminal-count flag.
//   clk, rst_n : clock, async active-low reset
//   en         : count this cycle
//   clr        : force count to 0 (wins over en)
//   tc         : count equals TERMINAL
module axa_timeout_counter #(
  parameter int W        = 8,
  parameter int TERMINAL = 63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (clr)   cnt_q <= '0;
    else if (en)    cnt_q <= cnt_q + 1'b1;
  end

  assign tc = (cnt_q == W'(TERMINAL));

endmodule

// File: rtl/axa_operand_loader.sv
// axa_operand_loader
// Collects eight FP32 words into the A/B operand registers of a 2x2 adder,
// fires Start, waits for Stable (with timeout), acknowledges and drains.
//   input_Clk, input_Reset        : clock, async active-low reset
//   input_Word/_Valid, output_Word_Ready : operand stream (accepted in LOAD only)
//   output_A11..A22, output_B11..B22    : registered operands
//   output_Start, input_Stable, output_C_Ack : adder handshake
//   output_Busy, output_Error     : status (Error is sticky until next accepted word)
// Optional: define AXA_LOADER_NAN_CHECK_EN to reject word sets containing Inf/NaN.
module axa_operand_loader
  import axa_operand_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        input_Clk,
  input  logic        input_Reset,
  input  logic [31:0] input_Word,
  input  logic        input_Word_Valid,
  output logic        output_Word_Ready,
  output logic [31:0] output_A11,
  output logic [31:0] output_A12,
  output logic [31:0] output_A21,
  output logic [31:0] output_A22,
  output logic [31:0] output_B11,
  output logic [31:0] output_B12,
  output logic [31:0] output_B21,
  output logic [31:0] output_B22,
  output logic        output_Start,
  input  logic        input_Stable,
  output logic        output_C_Ack,
  output logic        output_Busy,
  output logic        output_Error
);

  state_t state_q, state_d;
  logic [2:0] idx_q;
  logic [NUM_OPS-1:0][WORD_W-1:0] ops_q;
  logic err_q, err_d;

  logic accept, last_word, nan_hit, tmo_tc, tmo_hit;

  assign accept    = (state_q == ST_LOAD) && input_Word_Valid;
  assign last_word = accept && (idx_q == IDX_B22);

  // Count only while in RUN; held at zero elsewhere so every RUN starts fresh
  axa_timeout_counter #(
    .W        (8),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_tmo (
    .clk   (input_Clk),
    .rst_n (input_Reset),
    .en    (state_q == ST_RUN),
    .clr   (state_q != ST_RUN),
    .tc    (tmo_tc)
  );

  // Stable takes priority over a coincident timeout
  assign tmo_hit = (state_q == ST_RUN) && tmo_tc && !input_Stable;

`ifdef AXA_LOADER_NAN_CHECK_EN
  // Inspect the seven stored operands plus the word being accepted now
  always_comb begin
    nan_hit = is_inf_nan(input_Word);
    for (int i = 0; i < NUM_OPS - 1; i++)
      if (is_inf_nan(ops_q[i])) nan_hit = 1'b1;
  end
`else
  assign nan_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (last_word && !nan_hit) state_d = ST_RUN;
      ST_RUN:   if (input_Stable)          state_d = ST_ACK;
                else if (tmo_tc)           state_d = ST_LOAD;
      ST_ACK:                              state_d = ST_DRAIN;
      ST_DRAIN: if (!input_Stable)         state_d = ST_LOAD;
      default:                             state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (accept)                err_d = 1'b0;
    if (tmo_hit)               err_d = 1'b1;
    if (last_word && nan_hit)  err_d = 1'b1;
  end

  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) begin
      state_q <= ST_LOAD;
      idx_q   <= IDX_A11;
      ops_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        ops_q[idx_q] <= input_Word;
        idx_q        <= idx_q + 3'd1;  // wraps 7 -> 0
      end
    end
  end

  assign output_Word_Ready = (state_q == ST_LOAD);
  assign output_Start      = (state_q == ST_RUN);
  assign output_C_Ack      = (state_q == ST_ACK);
  assign output_Busy       = (state_q != ST_LOAD);
  assign output_Error      = err_q;

  assign output_A11 = ops_q[IDX_A11];
  assign output_A12 = ops_q[IDX_A12];
  assign output_A21 = ops_q[IDX_A21];
  assign output_A22 = ops_q[IDX_A22];
  assign output_B11 = ops_q[IDX_B11];
  assign output_B12 = ops_q[IDX_B12];
  assign output_B21 = ops_q[IDX_B21];
  assign output_B22 = ops_q[IDX_B22];

endmodule

// File: tb/tb_axa_operand_loader.sv
// tb_axa_operand_loader
// Directed bench for axa_operand_loader built with TIMEOUT_CYCLES=8.
// Honors AXA_LOADER_NAN_CHECK_EN for the Inf/NaN rejection case.
module tb_axa_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] word;
  logic        valid;
  logic        stable;
  logic        ready, start, c_ack, busy, error;
  logic [31:0] a11, a12, a21, a22, b11, b12, b21, b22;
  logic [31:0] ops [8];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axa_operand_loader #(.TIMEOUT_CYCLES(8)) dut (
    .input_Clk         (clk),
    .input_Reset       (rst_n),
    .input_Word        (word),
    .input_Word_Valid  (valid),
    .output_Word_Ready (ready),
    .output_A11        (a11),
    .output_A12        (a12),
    .output_A21        (a21),
    .output_A22        (a22),
    .output_B11        (b11),
    .output_B12        (b12),
    .output_B21        (b21),
    .output_B22        (b22),
    .output_Start      (start),
    .input_Stable      (stable),
    .output_C_Ack      (c_ack),
    .output_Busy       (busy),
    .output_Error      (error)
  );

  always_comb begin
    ops[0] = a11; ops[1] = a12; ops[2] = a21; ops[3] = a22;
    ops[4] = b11; ops[5] = b12; ops[6] = b21; ops[7] = b22;
  end

  logic [31:0] w1 [8];
  logic [31:0] w2 [8];
  logic [31:0] w3 [8];

  typedef struct {
    logic        vld;
    logic [31:0] wd;
    logic        exp_ready;
    logic        exp_start;
  } vec_t;
  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] w);
    valid = 1'b1;
    word  = w;
    tick();
    valid = 1'b0;
  endtask

  task automatic check_ops(input string name, input int set);
    for (int i = 0; i < 8; i++) begin
      case (set)
        1:       chk($sformatf("%s op%0d", name, i), ops[i], w1[i]);
        2:       chk($sformatf("%s op%0d", name, i), ops[i], w2[i]);
        default: chk($sformatf("%s op%0d", name, i), ops[i], w3[i]);
      endcase
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    w1 = '{32'h42FA0000, 32'h3EE04189, 32'h420A28F6, 32'h4148BC6A,
           32'h3A635B85, 32'h44961DC3, 32'h41980000, 32'h3FAB851F};
    w2 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    w3 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
           32'h40A00000, 32'h7FC00000, 32'h40E00000, 32'h41000000};

    // Valid toggles 1/0 across the set, then stays high (garbage) during RUN
    for (int i = 0; i < 8; i++) begin
      tbl[2*i]   = '{1'b1, w2[i],        1'b1, 1'b0};
      tbl[2*i+1] = '{1'b0, 32'hBAD0BAD0, 1'b1, 1'b0};
    end
    tbl[15] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
    for (int i = 16; i < 19; i++) tbl[i] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b1};

    rst_n = 1'b0; valid = 1'b0; word = '0; stable = 1'b0;
    #12;
    // ---- reset state
    chk("rst start", {31'd0, start}, 32'd0);
    chk("rst c_ack", {31'd0, c_ack}, 32'd0);
    chk("rst busy",  {31'd0, busy},  32'd0);
    chk("rst error", {31'd0, error}, 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst op%0d", i), ops[i], 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst ready", {31'd0, ready}, 32'd1);

    // ---- full load, adder answers after 5 cycles
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("load ready %0d", i), {31'd0, ready}, 32'd1);
      load_word(w1[i]);
    end
    chk("run start", {31'd0, start}, 32'd1);
    chk("run busy",  {31'd0, busy},  32'd1);
    chk("run ready", {31'd0, ready}, 32'd0);
    check_ops("load1", 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("run hold start %0d", i), {31'd0, start}, 32'd1);
    end
    stable = 1'b1;
    tick();
    chk("ack start", {31'd0, start}, 32'd0);
    chk("ack c_ack", {31'd0, c_ack}, 32'd1);
    chk("ack busy",  {31'd0, busy},  32'd1);
    tick();
    chk("drain c_ack", {31'd0, c_ack}, 32'd0);
    chk("drain ready", {31'd0, ready}, 32'd0);
    tick();
    chk("drain hold ready", {31'd0, ready}, 32'd0);
    stable = 1'b0;
    tick();
    chk("back ready", {31'd0, ready}, 32'd1);
    chk("back busy",  {31'd0, busy},  32'd0);
    chk("back error", {31'd0, error}, 32'd0);
    check_ops("hold1", 1);

    // ---- timeout: Stable never comes, 8 RUN cycles then LOAD with Error
    for (int i = 0; i < 8; i++) load_word(w2[i]);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("tmo start %0d", i), {31'd0, start}, 32'd1);
      chk($sformatf("tmo err %0d", i),   {31'd0, error}, 32'd0);
      tick();
    end
    chk("tmo last start", {31'd0, start}, 32'd1);
    tick();
    chk("tmo error", {31'd0, error}, 32'd1);
    chk("tmo ready", {31'd0, ready}, 32'd1);
    chk("tmo start off", {31'd0, start}, 32'd0);
    tick();
    chk("tmo error held", {31'd0, error}, 32'd1);
    load_word(32'h12345678);
    chk("tmo error clr", {31'd0, error}, 32'd0);
    do_reset();

    // ---- table: toggled Valid, then Valid held high during RUN
    for (int r = 0; r < 19; r++) begin
      valid = tbl[r].vld;
      word  = tbl[r].wd;
      #1;
      chk($sformatf("tbl ready r%0d", r), {31'd0, ready}, {31'd0, tbl[r].exp_ready});
      chk($sformatf("tbl start r%0d", r), {31'd0, start}, {31'd0, tbl[r].exp_start});
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    check_ops("tbl run", 2);
    stable = 1'b1;
    tick();
    tick();
    stable = 1'b0;
    tick();
    chk("tbl done ready", {31'd0, ready}, 32'd1);
    check_ops("tbl hold", 2);

    // ---- reset after 5 words, then a fresh set
    do_reset();
    for (int i = 0; i < 5; i++) load_word(w2[i]);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst a11", a11, 32'd0);
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) load_word(w1[i]);
    check_ops("after rst", 1);
    chk("after rst start", {31'd0, start}, 32'd1);
    // async reset drops Start within the cycle
    #2 rst_n = 1'b0;
    #1;
    chk("rst run start", {31'd0, start}, 32'd0);
    chk("rst run a11", a11, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- B12 = quiet NaN
    for (int i = 0; i < 8; i++) load_word(w3[i]);
`ifdef AXA_LOADER_NAN_CHECK_EN
    chk("nan error", {31'd0, error}, 32'd1);
    chk("nan start", {31'd0, start}, 32'd0);
    chk("nan ready", {31'd0, ready}, 32'd1);
    check_ops("nan keep", 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("nan no start %0d", i), {31'd0, start}, 32'd0);
    end
`else
    chk("nan error", {31'd0, error}, 32'd0);
    chk("nan start", {31'd0, start}, 32'd1);
    check_ops("nan ops", 3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
